// File: rtl/iir_dac_serializer_if.sv
// Sample/status/SPI bundle between the IIR filter sequencer and the DAC serializer.
interface iir_dac_serializer_if #(
  parameter int unsigned N_BITS = 32
);
  logic              sample_en_i;
  logic [N_BITS-1:0] y_i;
  logic              busy_o;
  logic              done_o;
  logic              sat_o;
  logic              overrun_o;
  logic              sclk_o;
  logic              cs_n_o;
  logic              mosi_o;

  // Sequencer side: drives samples, observes status and SPI pins
  modport master (
    output sample_en_i, y_i,
    input  busy_o, done_o, sat_o, overrun_o, sclk_o, cs_n_o, mosi_o
  );

  // Serializer side
  modport slave (
    input  sample_en_i, y_i,
    output busy_o, done_o, sat_o, overrun_o, sclk_o, cs_n_o, mosi_o
  );
endinterface

// File: rtl/iir_dac_serializer.sv
// IIR output stage: saturates a Q.FRAC_BITS sample to an offset-binary DAC
// code and shifts a 16-bit {CMD, code} frame out over SPI mode 0, MSB first.
// Optional build macro IIR_DAC_ROUND_EN selects round-to-nearest instead of
// truncation when reducing the sample to DAC_BITS.
module iir_dac_serializer #(
  parameter int unsigned N_BITS    = 32,
  parameter int unsigned FRAC_BITS = 16,
  parameter int unsigned DAC_BITS  = 12,
  parameter logic [3:0]  CMD       = 4'b0011,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  iir_dac_serializer_if.slave  bus
);

  localparam int unsigned SUM_W    = FRAC_BITS + 2;
  localparam int unsigned SHIFT    = FRAC_BITS + 1 - DAC_BITS;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic signed [N_BITS-1:0] Y_MAX = N_BITS'((64'd1 << FRAC_BITS) - 64'd1);
  localparam logic signed [N_BITS-1:0] Y_MIN = ~Y_MAX;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [15:0]      frame_q, frame_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sat_q, sat_d;
  logic             overrun_q, overrun_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;

  logic [FRAC_BITS:0]  y_sat_c;
  logic                clip_c;
  logic [SUM_W-1:0]    sum_c;
  logic [DAC_BITS-1:0] code_c;
  logic [15:0]         frame_c;
  logic                capture_c;

`ifdef IIR_DAC_ROUND_EN
  localparam int unsigned RND      = (FRAC_BITS >= DAC_BITS) ? (1 << (FRAC_BITS - DAC_BITS)) : 0;
  localparam int unsigned CODE_MAX = (1 << DAC_BITS) - 1;
  logic [SUM_W-1:0] code_full_c;
`endif

  // Saturate to [-1.0, 1.0), shift to offset binary, reduce to DAC_BITS
  always_comb begin
    clip_c  = 1'b0;
    y_sat_c = bus.y_i[FRAC_BITS:0];
    if ($signed(bus.y_i) > Y_MAX) begin
      clip_c  = 1'b1;
      y_sat_c = {1'b0, {FRAC_BITS{1'b1}}};
    end else if ($signed(bus.y_i) < Y_MIN) begin
      clip_c  = 1'b1;
      y_sat_c = {1'b1, FRAC_BITS'(0)};
    end
    // Adding 2^FRAC_BITS to a (FRAC_BITS+1)-bit two's complement value flips its MSB
    sum_c = SUM_W'({~y_sat_c[FRAC_BITS], y_sat_c[FRAC_BITS-1:0]});
`ifdef IIR_DAC_ROUND_EN
    code_full_c = (sum_c + SUM_W'(RND)) >> SHIFT;
    if (code_full_c > SUM_W'(CODE_MAX)) begin
      code_c = '1;
    end else begin
      code_c = DAC_BITS'(code_full_c);
    end
`else
    code_c = DAC_BITS'(sum_c >> SHIFT);
`endif
    frame_c = {CMD, 12'(12'(code_c) << (12 - DAC_BITS))};
  end

  // Next-state and output logic for IDLE/SHIFT/GAP sequencing
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sat_d     = sat_q;
    overrun_d = overrun_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;

    // The last GAP cycle behaves as IDLE so back-to-back frames run at 33*CLK_DIV
    capture_c = bus.sample_en_i &&
                ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (div_q == DIV_LAST)));

    case (state_q)
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            sclk_d = 1'b0;
            bit_d  = 4'(bit_q - 4'd1);
            mosi_d = frame_q[4'(bit_q - 4'd1)];
          end
        end else begin
          div_d = DIV_W'(div_q + 1'b1);
        end
      end
      ST_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          div_d = DIV_W'(div_q + 1'b1);
        end
      end
      default: ;
    endcase

    if (bus.sample_en_i && !capture_c) begin
      overrun_d = 1'b1;
    end

    if (capture_c) begin
      state_d = ST_SHIFT;
      frame_d = frame_c;
      sat_d   = clip_c;
      cs_n_d  = 1'b0;
      mosi_d  = frame_c[15];
      busy_d  = 1'b1;
      bit_d   = 4'd15;
      div_d   = '0;
      sclk_d  = 1'b0;
    end
  end

  // State register with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      mosi_q    <= mosi_d;
    end
  end

  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.sat_o     = sat_q;
  assign bus.overrun_o = overrun_q;
  assign bus.sclk_o    = sclk_q;
  assign bus.cs_n_o    = cs_n_q;
  assign bus.mosi_o    = mosi_q;

endmodule

// File: tb/tb_iir_dac_serializer.sv
// Directed bench for iir_dac_serializer with default parameters (CLK_DIV=4).
module tb_iir_dac_serializer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  iir_dac_serializer_if #(.N_BITS(32)) bus ();

  iir_dac_serializer #(
    .N_BITS(32), .FRAC_BITS(16), .DAC_BITS(12), .CMD(4'b0011), .CLK_DIV(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] frame;
  int          cs_low, done_at, done_cnt, nrise;
  logic        busy_last;
  logic        activity;
  logic [15:0] exp_rnd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe (optionally), then watch 132 cycles after the capture edge.
  task automatic run_frame(input bit do_strobe, input logic [31:0] y,
                           input int inject_at, input logic [31:0] inject_y,
                           input bit chain, input logic [31:0] chain_y,
                           output logic [15:0] fr, output int low, output int d_at,
                           output int d_cnt, output int rises, output logic busy_end);
    logic prev;
    fr = '0; low = 0; d_at = -1; d_cnt = 0; rises = 0; prev = 1'b0; busy_end = 1'b0;
    if (do_strobe) begin
      @(negedge clk);
      bus.sample_en_i = 1'b1;
      bus.y_i = y;
    end
    for (int c = 0; c < 132; c++) begin
      @(negedge clk);
      bus.sample_en_i = 1'b0;
      if (c == inject_at - 1) begin
        bus.sample_en_i = 1'b1;
        bus.y_i = inject_y;
      end
      if (chain && c == 131) begin
        bus.sample_en_i = 1'b1;
        bus.y_i = chain_y;
      end
      if (!bus.cs_n_o) low++;
      if (bus.done_o) begin
        d_cnt++;
        if (d_at < 0) d_at = c;
      end
      if (!prev && bus.sclk_o) begin
        rises++;
        fr = {fr[14:0], bus.mosi_o};
      end
      prev = bus.sclk_o;
      busy_end = bus.busy_o;
    end
  endtask

  initial begin
    bus.sample_en_i = 1'b0;
    bus.y_i = '0;
    reset = 1'b0;

    // Reset values
    #12;
    check("rst_sclk",    32'(bus.sclk_o),    32'd0);
    check("rst_cs_n",    32'(bus.cs_n_o),    32'd1);
    check("rst_mosi",    32'(bus.mosi_o),    32'd0);
    check("rst_busy",    32'(bus.busy_o),    32'd0);
    check("rst_done",    32'(bus.done_o),    32'd0);
    check("rst_sat",     32'(bus.sat_o),     32'd0);
    check("rst_overrun", 32'(bus.overrun_o), 32'd0);

    // No activity without a strobe
    @(negedge clk);
    reset = 1'b1;
    activity = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.sclk_o || !bus.cs_n_o || bus.busy_o || bus.mosi_o || bus.done_o) activity = 1'b1;
    end
    check("idle_quiet", 32'(activity), 32'd0);

    // Reset mid-idle
    reset = 1'b0;
    #1;
    check("idle_rst_cs_n", 32'(bus.cs_n_o), 32'd1);
    check("idle_rst_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Zero sample with full timing
    run_frame(1'b1, 32'h0000_0000, -1, '0, 1'b0, '0, frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("zero_frame",    32'(frame),     32'h3800);
    check("zero_sat",      32'(bus.sat_o), 32'd0);
    check("zero_cs_low",   32'(cs_low),    32'd128);
    check("zero_rises",    32'(nrise),     32'd16);
    check("zero_done_at",  32'(done_at),   32'd128);
    check("zero_done_cnt", 32'(done_cnt),  32'd1);
    check("zero_busy_131", 32'(busy_last), 32'd1);
    @(negedge clk);
    check("zero_busy_132", 32'(bus.busy_o), 32'd0);
    check("zero_cs_idle",  32'(bus.cs_n_o), 32'd1);

    // Saturation cases
    run_frame(1'b1, 32'h0002_0000, -1, '0, 1'b0, '0, frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("pos2_frame", 32'(frame),     32'h3FFF);
    check("pos2_sat",   32'(bus.sat_o), 32'd1);
    run_frame(1'b1, 32'hFFFF_0000, -1, '0, 1'b0, '0, frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("neg1_frame", 32'(frame),     32'h3000);
    check("neg1_sat",   32'(bus.sat_o), 32'd0);
    run_frame(1'b1, 32'h8000_0000, -1, '0, 1'b0, '0, frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("most_neg_frame", 32'(frame),     32'h3000);
    check("most_neg_sat",   32'(bus.sat_o), 32'd1);
    check("no_overrun_yet", 32'(bus.overrun_o), 32'd0);

    // Rounding behaviour
`ifdef IIR_DAC_ROUND_EN
    exp_rnd = 16'h3801;
`else
    exp_rnd = 16'h3800;
`endif
    run_frame(1'b1, 32'h0000_0010, -1, '0, 1'b0, '0, frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("lsb_frame", 32'(frame), 32'(exp_rnd));
    run_frame(1'b1, 32'h0000_FFFF, -1, '0, 1'b0, '0, frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("near1_frame", 32'(frame),     32'h3FFF);
    check("near1_sat",   32'(bus.sat_o), 32'd0);

    // Overrun: ignored strobe at k+10, then back-to-back strobe at k+132
    run_frame(1'b1, 32'h0000_4000, 10, 32'hFFFF_0000, 1'b1, 32'hFFFF_8000,
              frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("ovr_frame",   32'(frame),         32'h3A00);
    check("ovr_cs_low",  32'(cs_low),        32'd128);
    check("ovr_flag",    32'(bus.overrun_o), 32'd1);
    check("ovr_done_at", 32'(done_at),       32'd128);
    run_frame(1'b0, '0, -1, '0, 1'b0, '0, frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("b2b_frame",   32'(frame),         32'h3400);
    check("b2b_cs_low",  32'(cs_low),        32'd128);
    check("b2b_ovr",     32'(bus.overrun_o), 32'd1);
    check("b2b_sat",     32'(bus.sat_o),     32'd0);

    // Reset mid-frame
    @(negedge clk);
    bus.sample_en_i = 1'b1;
    bus.y_i = 32'h0001_0000;
    done_cnt = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      bus.sample_en_i = 1'b0;
      if (bus.done_o) done_cnt++;
    end
    check("mid_cs_low_before", 32'(bus.cs_n_o), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_cs_n",    32'(bus.cs_n_o),    32'd1);
    check("mid_rst_sclk",    32'(bus.sclk_o),    32'd0);
    check("mid_rst_mosi",    32'(bus.mosi_o),    32'd0);
    check("mid_rst_busy",    32'(bus.busy_o),    32'd0);
    check("mid_rst_overrun", 32'(bus.overrun_o), 32'd0);
    check("mid_rst_sat",     32'(bus.sat_o),     32'd0);
    repeat (5) begin
      @(negedge clk);
      if (bus.done_o) done_cnt++;
    end
    check("mid_no_done", 32'(done_cnt), 32'd0);
    reset = 1'b1;
    run_frame(1'b1, 32'hFFFF_0000, -1, '0, 1'b0, '0, frame, cs_low, done_at, done_cnt, nrise, busy_last);
    check("post_rst_frame",   32'(frame),    32'h3000);
    check("post_rst_cs_low",  32'(cs_low),   32'd128);
    check("post_rst_rises",   32'(nrise),    32'd16);
    check("post_rst_done_at", 32'(done_at),  32'd128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_dac_serializer.md
# iir_dac_serializer

Output stage directly downstream of the IIR filter. Captures one filtered sample `y_i` per `sample_en_i` strobe and converts it from two's-complement Q15.16 to a saturated offset-binary DAC code. It then shifts a 16-bit command+code frame to an external SPI DAC (mode 0, MSB first). Reports busy, frame-done, clipping and overrun status to the sequencing logic.

## Interface
- `N_BITS`, 32: width of `y_i`.
- `FRAC_BITS`, 16: fractional bits of `y_i`.
- `DAC_BITS`, 12: DAC code width. Legal range is 1..12 and `DAC_BITS <= FRAC_BITS+1`.
- `CMD`, 4'b0011: 4-bit DAC command prefix.
- `CLK_DIV`, 4: `clk` cycles per `sclk_o` half-period. Must be at least 1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; `reset=0` clears all state immediately.
- `sample_en_i` in 1: one-cycle strobe marking `y_i` valid.
- `y_i` in N_BITS: filter output, two's complement Q(N_BITS-FRAC_BITS-1).FRAC_BITS.
- `busy_o` out 1: a frame is in progress; new strobes are not accepted.
- `done_o` out 1: one-cycle pulse at frame end.
- `sat_o` out 1: the last captured sample was clipped.
- `overrun_o` out 1: sticky flag; a strobe arrived while busy.
- `sclk_o` out 1: SPI clock, idles low.
- `cs_n_o` out 1: SPI chip select, active-low.
- `mosi_o` out 1: SPI data.

## Operation
- **Reset values:** `sclk_o=0`, `cs_n_o=1`, `mosi_o=0`, `busy_o=0`, `done_o=0`, `sat_o=0`, `overrun_o=0`. State is IDLE and all counters are 0.
- **Conversion (combinational, registered at capture):**
  - Saturate `y_i` to [-2^FRAC_BITS, 2^FRAC_BITS-1], i.e. [-1.0, 1.0).
  - `sat_o` is set to 1 if clipping occurred.
  - Compute `code = (sat + 2^FRAC_BITS) >> (FRAC_BITS+1-DAC_BITS)`, giving an unsigned value in [0, 2^DAC_BITS-1].
  - Default values map 0.0 to 0x800.
- **Frame:** `{CMD, code, (12-DAC_BITS) zero bits}`, 16 bits, sent MSB first.
- **FSM states:** IDLE, SHIFT, GAP.
  - IDLE -> SHIFT on `sample_en_i=1`. On the same edge: frame and `sat_o` are loaded, `cs_n_o` goes to 0, `mosi_o` takes frame[15], `busy_o` goes to 1, and the bit counter is set to 15.
  - SHIFT: a divide counter runs 0..CLK_DIV-1 and toggles `sclk_o` at terminal count.
    - On each high->low `sclk_o` transition, the next bit is presented on `mosi_o`.
    - After the high phase of bit 0 ends, `sclk_o` goes to 0, `cs_n_o` to 1, `mosi_o` to 0, `done_o` pulses 1 for one cycle, and the FSM moves to GAP.
  - GAP: lasts CLK_DIV cycles, then the FSM returns to IDLE and `busy_o` goes to 0.
- **Strobe while busy (SHIFT or GAP):** the strobe is ignored. The frame in flight is unaffected and `overrun_o` is set to 1. `overrun_o` clears only on reset.
- **Strobe on the cycle `busy_o` falls:** the FSM is already in IDLE, so the strobe is accepted.
- **`sat_o`:** holds its value until the next accepted capture.
- **Reset mid-frame:** all outputs return to their reset values immediately (asynchronously). The partial frame is abandoned.

## Timing
- Strobe at edge k: `cs_n_o` reads 0 after edge k, and `mosi_o` holds frame[15] at the same time.
- First `sclk_o` rise at edge k+CLK_DIV. The DAC samples on rising edges and `mosi_o` is stable for CLK_DIV cycles around each rise.
- `cs_n_o` stays low for exactly 32·CLK_DIV cycles, with 16 `sclk_o` rising edges.
- `cs_n_o` rises and `done_o` pulses at edge k+32·CLK_DIV.
- `busy_o` falls at edge k+33·CLK_DIV. The earliest accepted next strobe is at that edge, i.e. 132 cycles with the defaults.
- Maximum sample rate is f_clk/(33·CLK_DIV).

## Configuration
- `IIR_DAC_ROUND_EN` defined:
  - Round to nearest by adding 2^(FRAC_BITS-DAC_BITS) before the shift.
  - A result above 2^DAC_BITS-1 clamps to 2^DAC_BITS-1, and `sat_o` is not set by this rounding clamp.
- `IIR_DAC_ROUND_EN` undefined: truncate, as in the conversion formula above.
- Timing and the frame format are identical in both builds.

## Test plan
- **Reset check:** assert `reset=0` mid-idle. All outputs are at their reset values; after release, no activity without a strobe.
- **Zero sample:** `y_i=0x0000_0000` with a strobe. The frame on `mosi_o` is 0x3800, `sat_o=0`, `cs_n_o` is low 128 cycles, `done_o` pulses at cycle 128, and `busy_o` falls at cycle 132.
- **Saturation:**
  - `y_i=0x0002_0000` (+2.0) gives frame 0x3FFF and `sat_o=1`.
  - `y_i=0xFFFF_0000` (-1.0) gives frame 0x3000 and `sat_o=0`.
  - `y_i=0x8000_0000` gives frame 0x3000 and `sat_o=1`.
- **Rounding:** `y_i=0x0000_0010`.
  - Without the macro, frame 0x3800.
  - With `IIR_DAC_ROUND_EN`, frame 0x3801.
  - `y_i=0x0000_FFFF` with the macro gives 0x3FFF and `sat_o=0`.
- **Overrun:** strobe at k, then a second strobe at k+10 with a different `y_i`. The first frame is sent unaltered and `overrun_o=1` persists; a strobe at k+132 is accepted.
- **Reset mid-frame:** pull `reset` low at k+50. `cs_n_o` goes to 1 and `sclk_o` to 0 immediately, with no `done_o` pulse. After release, a new strobe sends a complete, correct frame.
